// File: rtl/navigate.sv
// Motion sequencer: turns to a commanded heading or drives forward with a
// speed ramp, stopping on a blocked path or a newly seen side opening.
module navigate #(
   parameter logic [10:0] MAX_SPD  = 11'h2A0,
   parameter logic [10:0] SPD_INC  = 11'h020,
   parameter logic [11:0] HDNG_TOL = 12'h02C
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        strt_hdng,
   input  logic        strt_mv,
   input  logic        stp_lft,
   input  logic        stp_rght,
   input  logic [11:0] dsrd_hdng,
   input  logic [11:0] actl_hdng,
   input  logic        hdng_rdy,
   input  logic        lft_opn,
   input  logic        rght_opn,
   input  logic        frwrd_opn,
   output logic        mv_cmplt,
   output logic [10:0] frwrd_spd,
   output logic        moving
);

   typedef enum logic [1:0] {IDLE, HEADING, RAMP_UP, RAMP_DWN} state_t;

   localparam logic [10:0] FAST_DEC = {SPD_INC[9:0], 1'b0};

   state_t      state_q, state_d;
   logic [10:0] spd_q, spd_d;
   logic [10:0] dec_q, dec_d;
   logic        mvCmplt_q, mvCmplt_d;
   logic        lftOpn_q, rghtOpn_q;

   logic [11:0] hdngErr;
   logic [11:0] errMag;
   logic        hdngSettled;
   logic        lftEdge, rghtEdge, stopReq;
   logic [11:0] spdSum;
   logic [10:0] spdUp, spdDown;

   // Heading error wraps modulo 4096; the most negative value has no positive twin and never settles.
   assign hdngErr     = actl_hdng - dsrd_hdng;
   assign errMag      = hdngErr[11] ? (~hdngErr + 12'd1) : hdngErr;
   assign hdngSettled = (hdngErr != 12'h800) && (errMag < HDNG_TOL);

   assign lftEdge  = lft_opn & ~lftOpn_q;
   assign rghtEdge = rght_opn & ~rghtOpn_q;
   assign stopReq  = (stp_lft & lftEdge) | (stp_rght & rghtEdge);

   assign spdSum  = {1'b0, spd_q} + {1'b0, SPD_INC};
   assign spdUp   = (spdSum > {1'b0, MAX_SPD}) ? MAX_SPD : spdSum[10:0];
   assign spdDown = (spd_q > dec_q) ? (spd_q - dec_q) : 11'd0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         spd_q     <= '0;
         dec_q     <= '0;
         mvCmplt_q <= 1'b0;
         lftOpn_q  <= 1'b0;
         rghtOpn_q <= 1'b0;
      end else begin
         spd_q     <= spd_d;
         dec_q     <= dec_d;
         mvCmplt_q <= mvCmplt_d;
         lftOpn_q  <= lft_opn;
         rghtOpn_q <= rght_opn;
      end
   end

   // A blocked path outranks an opening edge; a coincident hdng_rdy still steps the speed first.
   always_comb begin
      state_d   = state_q;
      spd_d     = spd_q;
      dec_d     = dec_q;
      mvCmplt_d = 1'b0;
      case (state_q)
         IDLE: begin
            spd_d = '0;
            if (strt_hdng) begin
               state_d = HEADING;
            end else if (strt_mv) begin
               state_d = RAMP_UP;
            end
         end
         HEADING: begin
            spd_d = '0;
            if (hdng_rdy && hdngSettled) begin
               state_d   = IDLE;
               mvCmplt_d = 1'b1;
            end
         end
         RAMP_UP: begin
            if (hdng_rdy) begin
               spd_d = spdUp;
            end
            if (!frwrd_opn) begin
               state_d = RAMP_DWN;
               dec_d   = FAST_DEC;
            end else if (stopReq) begin
               state_d = RAMP_DWN;
               dec_d   = SPD_INC;
            end
         end
         RAMP_DWN: begin
            if (hdng_rdy) begin
               spd_d = spdDown;
               if (spdDown == 11'd0) begin
                  state_d   = IDLE;
                  mvCmplt_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            spd_d   = '0;
         end
      endcase
   end

   always_comb begin
      moving    = (state_q == RAMP_UP) || (state_q == RAMP_DWN);
      frwrd_spd = spd_q;
      mv_cmplt  = mvCmplt_q;
   end

endmodule
